// File: rtl/word_serializer_pkg.sv
// Shared constants for the word serializer and its select-driven mux.
// The word width is tied to mux_32, so these are the only legal sizes.
package word_serializer_pkg;

  localparam int SER_WIDTH = 32;
  localparam int SER_SEL_W = $clog2(SER_WIDTH);

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Map the beat counter onto a mux select; MSB-first walks the word downwards.
  function automatic logic [SER_SEL_W-1:0] bit_select(
    input logic [SER_SEL_W-1:0] count,
    input logic                 msb_first
  );
    if (msb_first) begin
      bit_select = ~count;
    end else begin
      bit_select = count;
    end
  endfunction

endpackage

// File: rtl/mux_32.sv
// 32-to-1 single-bit multiplexer: y = options[sel].
module mux_32
  import word_serializer_pkg::*;
(
  input  logic [SER_SEL_W-1:0] sel,
  input  logic [SER_WIDTH-1:0] options,
  output logic                 y
);

  // Pick the selected option bit.
  always_comb begin
    y = options[sel];
  end

endmodule

// File: rtl/word_serializer.sv
// Word-to-bit serializer: takes a 32-bit word over valid/ready and streams
// it one bit per accepted beat by sweeping a mux_32 select across a held
// copy of the word. The last beat of a word can accept the next word in the
// same cycle, so a held upstream valid streams without bubbles.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,  // only 32 is legal while mux_32 is the selector
  parameter int SEL_W     = SER_SEL_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_bit,
  output logic             o_last,
  output logic [SEL_W-1:0] o_sel
);

  localparam logic [SEL_W-1:0] COUNT_ZERO = SEL_W'(0);
  localparam logic [SEL_W-1:0] COUNT_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] COUNT_LAST = SEL_W'(WIDTH - 1);

  state_t           state_r;
  logic [SEL_W-1:0] count_r;
  logic [WIDTH-1:0] word_r;

  logic             shifting_s;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic             beat_s;
  logic [SEL_W-1:0] sel_s;
  logic             bit_s;

  // Decode handshake qualifiers from the registered state.
  always_comb begin
    shifting_s = (state_r == ST_SHIFT);
    last_s     = shifting_s && (count_r == COUNT_LAST);
    ready_s    = (state_r == ST_IDLE) || (shifting_s && o_ready && last_s);
    accept_s   = i_valid && ready_s;
    beat_s     = shifting_s && o_ready;
    sel_s      = bit_select(count_r, MSB_FIRST);
  end

  mux_32 u_mux (
    .sel     (sel_s),
    .options (word_r),
    .y       (bit_s)
  );

  // Drive the ports from the decoded state and the mux output.
  always_comb begin
    i_ready = ready_s;
    o_valid = shifting_s;
    o_last  = last_s;
    o_sel   = sel_s;
    o_bit   = bit_s;
  end

  // FSM, beat counter and held word; the final beat may reload in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= COUNT_ZERO;
      word_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            word_r  <= i_data;
            count_r <= COUNT_ZERO;
            state_r <= ST_SHIFT;
          end else begin
            count_r <= COUNT_ZERO;
          end
        end
        ST_SHIFT: begin
          if (beat_s) begin
            if (last_s) begin
              count_r <= COUNT_ZERO;
              if (accept_s) begin
                word_r  <= i_data;
                state_r <= ST_SHIFT;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              count_r <= count_r + COUNT_ONE;
            end
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= COUNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: a queue-of-bits reference model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_word_serializer;
  import word_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready = 1'b1;
  logic [31:0] i_data = 32'h0;
  logic        i_ready, o_valid, o_bit, o_last;
  logic [4:0]  o_sel;

  word_serializer #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_bit   (o_bit),
    .o_last  (o_last),
    .o_sel   (o_sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit started = 1'b0;

  // Reference: the bits still owed for the current word, oldest first.
  bit          exp_q[$];
  logic [31:0] word_q[$];
  logic [31:0] rx;
  bit          m_ready;
  int          n;

  typedef struct {
    logic       b;
    logic [4:0] sel;
    logic       last;
    int         cyc;
  } beat_t;
  beat_t log_q[$];

  logic       prev_stall = 1'b0;
  logic [4:0] prev_sel;
  logic       prev_bit;

  int ready_mode = 0;
  int pat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model update on each rising edge.
  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst) begin
      exp_q.delete();
      word_q.delete();
    end else begin
      m_ready = (exp_q.size() == 0) || (o_ready && exp_q.size() == 1);
      if (exp_q.size() > 0 && o_ready) exp_q.delete(0);
      if (i_valid && m_ready) begin
        for (int i = 0; i < 32; i++) exp_q.push_back(i_data[i]);
        word_q.push_back(i_data);
      end
    end
  end

  // Compare DUT against the model, log beats, reassemble words.
  always @(negedge clk) begin
    if (started) begin
      n = exp_q.size();
      check("o_valid", {31'h0, o_valid}, (n > 0) ? 32'h1 : 32'h0);
      check("i_ready", {31'h0, i_ready}, ((n == 0) || (o_ready && n == 1)) ? 32'h1 : 32'h0);
      check("o_last", {31'h0, o_last}, (n == 1) ? 32'h1 : 32'h0);
      check("o_sel", {27'h0, o_sel}, (n > 0) ? 32'(32 - n) : 32'h0);
      if (n > 0) check("o_bit", {31'h0, o_bit}, {31'h0, exp_q[0]});
      if (prev_stall) begin
        check("hold_sel", {27'h0, o_sel}, {27'h0, prev_sel});
        check("hold_bit", {31'h0, o_bit}, {31'h0, prev_bit});
      end
      prev_stall = o_valid && !o_ready && !rst;
      prev_sel   = o_sel;
      prev_bit   = o_bit;
      if (o_valid && o_ready && !rst) log_q.push_back('{o_bit, o_sel, o_last, cyc});
      if (n > 0 && o_ready && !rst) begin
        rx[32 - n] = o_bit;
        if (n == 1 && word_q.size() > 0) begin
          check("reassembled", rx, word_q[0]);
          word_q.delete(0);
        end
      end
    end
  end

  // Downstream ready generator: 0 = always, 1 = random, 2 = 1,0,0,1 pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: o_ready = 1'b1;
        1: o_ready = 1'($urandom_range(0, 1));
        default: begin
          o_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
          pat++;
        end
      endcase
    end
  end

  task automatic send(input logic [31:0] w);
    bit acc = 1'b0;
    i_valid = 1'b1;
    i_data  = w;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int errs;
    int ones;
    logic [31:0] one;
    logic [31:0] w;

    // Reset held for two edges, then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", {31'h0, o_valid}, 32'h0);
    check("rst_o_sel", {27'h0, o_sel}, 32'h0);
    check("rst_i_ready", {31'h0, i_ready}, 32'h1);
    check("rst_o_last", {31'h0, o_last}, 32'h0);
    check("rst_o_bit", {31'h0, o_bit}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_o_valid", {31'h0, o_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Single word 8000_0001.
    log_q.delete();
    send(32'h8000_0001);
    i_valid = 1'b0;
    i_data  = $urandom;
    drain();
    check("single_len", 32'(log_q.size()), 32'd32);
    if (log_q.size() == 32) begin
      for (int k = 0; k < 32; k++) begin
        check("single_bit", {31'h0, log_q[k].b}, (k == 0 || k == 31) ? 32'h1 : 32'h0);
        check("single_sel", {27'h0, log_q[k].sel}, 32'(k));
        check("single_last", {31'h0, log_q[k].last}, (k == 31) ? 32'h1 : 32'h0);
      end
    end
    @(negedge clk);
    check("ready_after", {31'h0, i_ready}, 32'h1);
    @(posedge clk);
    #1;

    // One-hot sweep.
    errs = 0;
    one = 32'h1;
    for (int i = 0; i < 32; i++) begin
      log_q.delete();
      send(one << i);
      i_valid = 1'b0;
      drain();
      if (log_q.size() != 32) errs++;
      else for (int k = 0; k < 32; k++) if (log_q[k].b !== ((k == i) ? 1'b1 : 1'b0)) errs++;
    end
    check("onehot_errors", 32'(errs), 32'h0);

    // Backpressure 1,0,0,1.
    ready_mode = 2;
    pat = 0;
    log_q.delete();
    send(32'hA5A5_A5A5);
    i_valid = 1'b0;
    drain();
    w = 32'h0;
    if (log_q.size() == 32) for (int k = 0; k < 32; k++) w[k] = log_q[k].b;
    check("bp_word", w, 32'hA5A5_A5A5);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Back-to-back with valid held.
    log_q.delete();
    send(32'hFFFF_FFFF);
    send(32'h0000_0000);
    i_valid = 1'b0;
    drain();
    check("b2b_len", 32'(log_q.size()), 32'd64);
    if (log_q.size() == 64) begin
      check("b2b_span", 32'(log_q[63].cyc - log_q[0].cyc), 32'd63);
      ones = 0;
      for (int k = 0; k < 32; k++) ones += int'(log_q[k].b);
      check("b2b_ones_first", 32'(ones), 32'd32);
      ones = 0;
      for (int k = 32; k < 64; k++) ones += int'(log_q[k].b);
      check("b2b_ones_second", 32'(ones), 32'd0);
    end

    // Reset in the middle of a word.
    log_q.delete();
    send(32'h1234_5678);
    i_valid = 1'b0;
    for (int t = 0; t < 100 && log_q.size() < 10; t++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_o_valid", {31'h0, o_valid}, 32'h0);
    check("mid_rst_i_ready", {31'h0, i_ready}, 32'h1);
    check("mid_rst_o_last", {31'h0, o_last}, 32'h0);
    check("mid_rst_beats", 32'(log_q.size()), 32'd10);
    errs = 0;
    foreach (log_q[k]) if (log_q[k].last) errs++;
    check("mid_rst_no_last", 32'(errs), 32'h0);
    @(posedge clk);
    #1;
    log_q.delete();
    send(32'h0000_0003);
    i_valid = 1'b0;
    drain();
    check("post_rst_len", 32'(log_q.size()), 32'd32);
    if (log_q.size() == 32)
      for (int k = 0; k < 4; k++)
        check("post_rst_bit", {31'h0, log_q[k].b}, (k < 2) ? 32'h1 : 32'h0);

    // Randomized traffic with random ready and noisy data between words.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send($urandom);
      if ($urandom_range(0, 1) == 1) begin
        i_valid = 1'b0;
        repeat ($urandom_range(1, 40)) begin
          i_data = $urandom;
          @(posedge clk);
          #1;
        end
      end
    end
    i_valid = 1'b0;
    drain();
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Accepts a 32-bit word over a valid/ready handshake and streams it out one bit per accepted beat, index 0 first.
- Internally drives the 5-bit select of a mux_32 instance, sweeping it 0..31 across a held copy of the word.
- Sits directly upstream of the bit-serial consumers, such as the shift/LED/SPI stages.
- Gives the mux a sequenced select source instead of a hand-driven one.

Parameters:
- WIDTH, 32, word width. Fixed at 32 while mux_32 is the selector; any other value is illegal.
- SEL_W, 5, select/counter width, equal to $clog2(WIDTH).
- MSB_FIRST, 0, 0 means bit 0 goes out first; 1 means bit WIDTH-1 goes out first (select = ~count).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream word present.
- i_ready  output  1  block can accept a word this cycle.
- i_data  input  WIDTH  word to serialize; sampled only on the accept cycle.
- o_valid  output  1  o_bit is valid.
- o_ready  input  1  downstream takes o_bit this cycle.
- o_bit  output  1  current serial bit, taken from the mux_32 output.
- o_last  output  1  current bit is the final bit of the word.
- o_sel  output  SEL_W  current mux select, exported for debug and visibility.

Behaviour:
- Reset: clk and rst as named; reset is synchronous, active-high, single clock domain.
  - rst high at a rising edge sets state=IDLE, count=0, word register=0.
  - The following outputs result: o_valid=0, o_last=0, o_sel=0, o_bit=0, i_ready=1.
- States: IDLE, SHIFT.
- Accept: accept = i_valid && i_ready.
  - On accept, the word register takes i_data, count=0, and state becomes SHIFT.
- i_ready = (state==IDLE) || (state==SHIFT && o_ready && o_last).
  - This gives a back-to-back reload with no bubble.
- In SHIFT:
  - o_valid=1.
  - o_sel = MSB_FIRST ? ~count : count.
  - o_bit = word[o_sel] through mux_32, combinational from registered state.
  - o_last = (count==WIDTH-1).
- Beat: beat = o_valid && o_ready.
  - On a beat with !o_last: count increments.
  - On a beat with o_last: if accept happens in the same cycle, reload and stay in SHIFT with count=0; otherwise go to IDLE with count=0.
- Latency: a word accepted at edge N presents bit 0 at edge N+1, meaning o_valid is high in the cycle after the accept edge.
- Throughput: with o_ready held high, one bit per cycle, 32 cycles per word, continuous across words.
- Backpressure: while o_ready=0, count, o_sel, o_bit and o_last hold stable and o_valid stays high.
- i_valid while busy (not last beat): the word is not accepted and i_data is ignored. Upstream must hold the word until i_ready.
- Counter arithmetic: unsigned SEL_W bits. It never wraps past WIDTH-1, because the o_last beat resets it explicitly.
- Reset mid-word: the partial word is abandoned. o_valid drops on the reset edge and no o_last is emitted for that word.
- i_data changing outside the accept cycle has no effect on output.
- All outputs are free of X after the first reset edge.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and the WIDTH/SEL_W constants, so mux_32 and the bench use the same widths.
- One sub-module: mux_32 (select = o_sel, options = word register, output = o_bit), instantiated unchanged.
- FSM, counter and word register live in word_serializer itself.

Test Plan:
- Reset then idle: hold rst 2 cycles -> o_valid=0, o_sel=0, i_ready=1. Deassert with i_valid=0 -> state stays idle for 10 cycles.
- Single word, o_ready=1, i_data=32'h8000_0001:
  - Serial stream is 1, then 30 zeros, then 1.
  - o_sel goes 0..31.
  - o_last is high only on the beat with o_sel=31.
  - i_ready returns to 1 on the next cycle.
- One-hot sweep: for i=0..31 send 1<<i -> exactly one 1 bit, at beat i; the bench counts 0 errors.
- Backpressure: i_data=32'hA5A5_A5A5, o_ready toggled 1,0,0,1,... -> o_bit/o_sel are stable during every o_ready=0 cycle, and the reassembled word equals A5A5_A5A5.
- Back-to-back: 32'hFFFF_FFFF then 32'h0000_0000 with i_valid held -> the second accept coincides with the first word's o_last beat, giving 64 consecutive valid beats (32 ones, 32 zeros) with no bubble.
- Mid-word reset: assert rst after beat 10 of 32'h1234_5678 -> o_valid=0 on the next cycle, no o_last, i_ready=1. A new word 32'h0000_0003 then streams correctly from bit 0.
